// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer and press/release/repeat
// pulse generator for raw push-button inputs.
//
// Each key channel normalises polarity, passes through a 2-flop synchroniser
// and feeds an independent four-state FSM. All outputs are registered.
// dbg_state exposes every channel's FSM state, two bits per key, with key k
// at bits [2k+1:2k]. The encoding is IDLE=0, HELD=1, REPEAT=2, REL_DB=3.
//
// Press debounce counts stable cycles while in IDLE. Release debounce treats
// the HELD->REL_DB transition edge as its first stable cycle. This gives
// press and release the same end-to-end latency: the pulse appears after
// sampling edge E+1+DEBOUNCE_CYCLES.
module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter bit KEY_ACTIVE_LOW  = 1'b0,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [NUM_KEYS-1:0]   KEY_RAW,
  output logic [NUM_KEYS-1:0]   KEY_LEVEL,
  output logic [NUM_KEYS-1:0]   KEY_PRESS,
  output logic [NUM_KEYS-1:0]   KEY_REPEAT,
  output logic [NUM_KEYS-1:0]   KEY_RELEASE,
  output logic [2*NUM_KEYS-1:0] dbg_state
);

  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_ALL + 1);

  // Terminal counts. Guarded so that degenerate parameter values never go negative.
  localparam logic [CW-1:0] DB_LAST  = CW'((DEBOUNCE_CYCLES >= 1) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] REL_LAST = CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] RD_LAST  = CW'((REPEAT_DELAY >= 1) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] RP_LAST  = CW'((REPEAT_PERIOD >= 1) ? REPEAT_PERIOD - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);
  // With a one-cycle debounce, a release is accepted on the first low sample.
  localparam bit            DB_SINGLE = (DEBOUNCE_CYCLES <= 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_REL_DB = 2'd3
  } state_t;

  // Saturating increment, so a counter can never wrap back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  logic [NUM_KEYS-1:0] pressed_raw;
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;

  // Normalise so that 1 always means pressed downstream.
  assign pressed_raw = KEY_RAW ^ {NUM_KEYS{KEY_ACTIVE_LOW}};

  // Two-flop synchroniser. It resets to the not-pressed value.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rep_q, rep_d;
    logic          rel_q, rel_d;
    logic          s;

    assign s = sync2_q[k];

    // Next-state, counter and pulse decode for one key channel.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rep_d   = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s) begin
            if (cnt_q == DB_LAST) begin
              state_d = ST_HELD;
              level_d = 1'b1;
              press_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (!s) begin
            if (DB_SINGLE) begin
              state_d = ST_IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              state_d = ST_REL_DB;
            end
            cnt_d = '0;
          end else if (REPEAT_EN) begin
            if (cnt_q == RD_LAST) begin
              state_d = ST_REPEAT;
              press_d = 1'b1;
              rep_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end
        end
        ST_REPEAT: begin
          if (!s) begin
            if (DB_SINGLE) begin
              state_d = ST_IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              state_d = ST_REL_DB;
            end
            cnt_d = '0;
          end else if (cnt_q == RP_LAST) begin
            press_d = 1'b1;
            rep_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        ST_REL_DB: begin
          if (!s) begin
            if (cnt_q == REL_LAST) begin
              state_d = ST_IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end else begin
            // A bounce back high cancels the release. Repeat timing starts over.
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    // Channel state and registered outputs. Reset drops everything, with no release pulse.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rep_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rep_q   <= rep_d;
        rel_q   <= rel_d;
      end
    end

    assign KEY_LEVEL[k]         = level_q;
    assign KEY_PRESS[k]         = press_q;
    assign KEY_REPEAT[k]        = rep_q;
    assign KEY_RELEASE[k]       = rel_q;
    assign dbg_state[2*k +: 2]  = state_q;
  end

endmodule
